iq_demod_decim: RTL and testbench

Parametrised I/Q demodulator core: it takes offset-binary ADC samples and an external quadrature local oscillator (NCO sin/cos), mixes them, and produces decimated I and Q samples. Decimation uses integrate-and-dump with a runtime-selectable power-of-two length. It sits between the ADC input converter and the DAC/output stage of the demodulator top level. It replaces the free-running mixer-plus-FIR path with a handshaked, saturating output, an overrun flag, and a DAC-ready unsigned mirror of I or Q.

---
 rtl/iq_demod_decim_if.sv | 23 ++
 rtl/iq_demod_decim.sv | 171 +++++++++++++++++
 tb/tb_iq_demod_decim.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_demod_decim_if.sv
// rtl/iq_demod_decim_if.sv - sample input and I/Q result handshake bundle
interface iq_demod_decim_if #(
  parameter int DW = 14
) ();
  logic                 in_valid;
  logic [DW-1:0]        adc_data;
  logic signed [DW-1:0] lo_sin;
  logic signed [DW-1:0] lo_cos;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;

  modport master (
    output in_valid, adc_data, lo_sin, lo_cos, out_ready,
    input  out_valid, out_i, out_q
  );

  modport slave (
    input  in_valid, adc_data, lo_sin, lo_cos, out_ready,
    output out_valid, out_i, out_q
  );
endinterface

// File: rtl/iq_demod_decim.sv
// rtl/iq_demod_decim.sv - I/Q mixer with power-of-two integrate-and-dump decimation
// Four stages: capture, multiply, accumulate/dump, saturate and hand off.
module iq_demod_decim #(
  parameter int DW           = 14,
  parameter int LOG2_DEC_MAX = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [3:0]    dec_log2,
  input  logic          dac_sel,
  input  logic          clr_overrun,
  output logic [DW-1:0] dac_data,
  output logic          overrun,
  iq_demod_decim_if.slave bus
);
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + LOG2_DEC_MAX;
  localparam int CW = (LOG2_DEC_MAX > 0) ? LOG2_DEC_MAX : 1;
  localparam logic [3:0] DEC_MAX = 4'(LOG2_DEC_MAX);
  localparam logic [5:0] SH_BASE = 6'(DW - 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] x_q, x_d, sin_q, sin_d, cos_q, cos_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PW-1:0] pi_q, pi_d, pq_q, pq_d;
  logic signed [AW-1:0] acci_q, acci_d, accq_q, accq_d;
  logic signed [AW-1:0] dumpi_q, dumpi_d, dumpq_q, dumpq_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           dec_act_q, dec_act_d, dump_dec_q, dump_dec_d;
  logic                 out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic signed [DW-1:0] outi_q, outi_d, outq_q, outq_d;
  logic [DW-1:0]        dac_q, dac_d;

  logic [3:0]           dec_lim, cur_dec;
  logic                 blk_end, accept, drop;
  logic signed [AW-1:0] ext_pi, ext_pq, sum_i, sum_q, shi, shq;
  logic signed [DW-1:0] res_i, res_q;

  function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_HI) return {1'b0, {(DW-1){1'b1}}};
    if (v < SAT_LO) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  always_comb begin
    x_d   = {~bus.adc_data[DW-1], bus.adc_data[DW-2:0]};
    sin_d = bus.lo_sin;
    cos_d = bus.lo_cos;
    v1_d  = bus.in_valid && enable;
    pi_d  = PW'(x_q) * PW'(cos_q);
    pq_d  = PW'(x_q) * PW'(sin_q);
    v2_d  = v1_q;
  end

  // The block length is latched on the first sample, so it must be used for that sample too.
  always_comb begin
    dec_lim = (dec_log2 > DEC_MAX) ? DEC_MAX : dec_log2;
    cur_dec = (cnt_q == '0) ? dec_lim : dec_act_q;
    blk_end = ({1'b0, cnt_q} == (((CW+1)'(1)) << cur_dec) - (CW+1)'(1));
    ext_pi  = {{(AW-PW){pi_q[PW-1]}}, pi_q};
    ext_pq  = {{(AW-PW){pq_q[PW-1]}}, pq_q};
    sum_i   = acci_q + ext_pi;
    sum_q   = accq_q + ext_pq;

    acci_d     = acci_q;
    accq_d     = accq_q;
    cnt_d      = cnt_q;
    dec_act_d  = dec_act_q;
    dumpi_d    = dumpi_q;
    dumpq_d    = dumpq_q;
    dump_dec_d = dump_dec_q;
    v3_d       = 1'b0;
    if (v2_q) begin
      if (cnt_q == '0) dec_act_d = dec_lim;
      if (blk_end) begin
        dumpi_d    = sum_i;
        dumpq_d    = sum_q;
        dump_dec_d = cur_dec;
        v3_d       = 1'b1;
        acci_d     = '0;
        accq_d     = '0;
        cnt_d      = '0;
      end else begin
        acci_d = sum_i;
        accq_d = sum_q;
        cnt_d  = cnt_q + CW'(1);
      end
    end
    if (!enable) begin
      acci_d = '0;
      accq_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    shi    = dumpi_q >>> (SH_BASE + {2'b00, dump_dec_q});
    shq    = dumpq_q >>> (SH_BASE + {2'b00, dump_dec_q});
    res_i  = sat(shi);
    res_q  = sat(shq);
    accept = out_valid_q && bus.out_ready;
    drop   = v3_q && out_valid_q && !bus.out_ready;

    out_valid_d = out_valid_q;
    outi_d      = outi_q;
    outq_d      = outq_q;
    if (v3_q && !drop) begin
      out_valid_d = 1'b1;
      outi_d      = res_i;
      outq_d      = res_q;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    dac_d = dac_sel ? {~outq_q[DW-1], outq_q[DW-2:0]} : {~outi_q[DW-1], outi_q[DW-2:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      v1_q        <= 1'b0;
      pi_q        <= '0;
      pq_q        <= '0;
      v2_q        <= 1'b0;
      acci_q      <= '0;
      accq_q      <= '0;
      cnt_q       <= '0;
      dec_act_q   <= '0;
      dumpi_q     <= '0;
      dumpq_q     <= '0;
      dump_dec_q  <= '0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      outi_q      <= '0;
      outq_q      <= '0;
      overrun_q   <= 1'b0;
      dac_q       <= {1'b1, {(DW-1){1'b0}}};
    end else begin
      x_q         <= x_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      v1_q        <= v1_d;
      pi_q        <= pi_d;
      pq_q        <= pq_d;
      v2_q        <= v2_d;
      acci_q      <= acci_d;
      accq_q      <= accq_d;
      cnt_q       <= cnt_d;
      dec_act_q   <= dec_act_d;
      dumpi_q     <= dumpi_d;
      dumpq_q     <= dumpq_d;
      dump_dec_q  <= dump_dec_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      outi_q      <= outi_d;
      outq_q      <= outq_d;
      overrun_q   <= overrun_d;
      dac_q       <= dac_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = outi_q;
  assign bus.out_q     = outq_q;
  assign dac_data      = dac_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_iq_demod_decim.sv
// tb/tb_iq_demod_decim.sv - scoreboard bench for iq_demod_decim
module tb_iq_demod_decim;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    dec_log2 = 4'd0;
  logic          dac_sel = 1'b0;
  logic          clr_overrun = 1'b0;
  logic [DW-1:0] dac_data;
  logic          overrun;

  iq_demod_decim_if #(.DW(DW)) bus ();

  iq_demod_decim #(.DW(DW), .LOG2_DEC_MAX(10)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .dec_log2    (dec_log2),
    .dac_sel     (dac_sel),
    .clr_overrun (clr_overrun),
    .dac_data    (dac_data),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] got_q[$];
  int     m_cnt = 0;
  int     m_dec = 0;
  longint m_ai = 0;
  longint m_aq = 0;

  always @(negedge clk)
    if (reset_n && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_i, bus.out_q});

  function automatic logic [DW-1:0] sat_ref(input longint v);
    longint r;
    r = v;
    if (v > 8191) r = 8191;
    if (v < -8192) r = -8192;
    return r[DW-1:0];
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_ai = 0;
    m_aq = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [DW-1:0] a, input logic signed [DW-1:0] c,
                             input logic signed [DW-1:0] s);
    logic signed [DW-1:0] x;
    longint xl;
    x = {~a[DW-1], a[DW-2:0]};
    xl = x;
    bus.adc_data = a;
    bus.lo_cos = c;
    bus.lo_sin = s;
    bus.in_valid = 1'b1;
    if (enable) begin
      if (m_cnt == 0) m_dec = (dec_log2 > 4'd10) ? 10 : int'(dec_log2);
      m_ai += xl * longint'(c);
      m_aq += xl * longint'(s);
      if (m_cnt == (1 << m_dec) - 1) begin
        exp_q.push_back({sat_ref(m_ai >>> (DW - 1 + m_dec)), sat_ref(m_aq >>> (DW - 1 + m_dec))});
        model_clear();
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      @(posedge clk);
      #1;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    idle(2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.out_valid); end
    total++; if (dac_data !== 14'h2000) begin bad++; $display("FAIL rst_dac got=%h want=2000", dac_data); end
    reset_n = 1'b1;
    enable = 1'b1;
    idle(2);
    total++; if (bus.out_i !== 14'h0) begin bad++; $display("FAIL rst_out_i got=%h want=0", bus.out_i); end
    total++; if (bus.out_q !== 14'h0) begin bad++; $display("FAIL rst_out_q got=%h want=0", bus.out_q); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0b want=0", overrun); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [2*DW-1:0] e, g;
    bus.out_ready = 1'b1;
    dec_log2 = 4'd2;
    idle(3);
    repeat (4) push_sample(14'h3FFF, 14'sd8191, 14'sd0);
    idle(2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", bus.out_valid); end
    idle(1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_i !== 14'd8190) begin bad++; $display("FAIL basic_out_i got=%0d want=8190", bus.out_i); end
    total++; if (bus.out_q !== 14'd0) begin bad++; $display("FAIL basic_out_q got=%0d want=0", bus.out_q); end
    idle(1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b want=0", bus.out_valid); end
    total++; if (dac_data !== 14'h3FFE) begin bad++; $display("FAIL basic_dac_i got=%h want=3ffe", dac_data); end
    dac_sel = 1'b1;
    idle(1);
    total++; if (dac_data !== 14'h2000) begin bad++; $display("FAIL basic_dac_q got=%h want=2000", dac_data); end
    dac_sel = 1'b0;
    wait_results(exp_q.size(), 20, ok);
    total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL basic_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_saturate();
    bit ok;
    logic [2*DW-1:0] e, g;
    repeat (4) push_sample(14'h0000, -14'sd8192, 14'sd8191);
    wait_results(exp_q.size(), 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    total++; if (bus.out_i !== 14'h1FFF) begin bad++; $display("FAIL sat_out_i got=%h want=1fff", bus.out_i); end
    total++; if (bus.out_q !== 14'h2001) begin bad++; $display("FAIL sat_out_q got=%h want=2001", bus.out_q); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL sat_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    bit ok;
    logic [2*DW-1:0] e, g, first;
    bus.out_ready = 1'b0;
    dec_log2 = 4'd0;
    idle(3);
    push_sample(14'h3FFF, 14'sd8191, 14'sd0);
    push_sample(14'h2000 + 14'd1000, 14'sd100, -14'sd200);
    push_sample(14'h1000, 14'sd3000, 14'sd4000);
    idle(5);
    first = exp_q[0];
    exp_q.delete();
    exp_q.push_back(first);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_i !== 14'd8190) begin bad++; $display("FAIL ovr_held_i got=%0d want=8190", bus.out_i); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want=1", overrun); end
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b want=0", overrun); end
    bus.out_ready = 1'b1;
    idle(1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%0b want=0", bus.out_valid); end
    wait_results(1, 10, ok);
    total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL ovr_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_dec_switch();
    bit ok;
    logic [2*DW-1:0] e, g;
    dec_log2 = 4'd2;
    idle(3);
    push_sample(14'h2400, 14'sd5000, -14'sd3000);
    push_sample(14'h3100, -14'sd700, 14'sd6000);
    idle(3);
    dec_log2 = 4'd3;
    push_sample(14'h0800, 14'sd1234, 14'sd4321);
    push_sample(14'h3F00, 14'sd8000, -14'sd8000);
    idle(6);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL dec_first_block got=%0d want=1", got_q.size()); end
    for (int i = 0; i < 7; i++) push_sample(14'h2000 + 14'(i * 900), 14'sd6000, -14'sd2500);
    idle(6);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL dec_second_early got=%0d want=1", got_q.size()); end
    push_sample(14'h0100, -14'sd4000, 14'sd7000);
    wait_results(2, 10, ok);
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL dec_second_block got=%0d want=2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL dec_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    dec_log2 = 4'd15;
    idle(3);
    repeat (1023) push_sample(14'h3FFF, 14'sd8191, 14'sd0);
    idle(6);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL dec_max_early got=%0d want=0", got_q.size()); end
    push_sample(14'h3FFF, 14'sd8191, 14'sd0);
    wait_results(1, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL dec_max_count got=%0d want=1", got_q.size()); end
    total++; if (bus.out_i !== 14'd8190) begin bad++; $display("FAIL dec_max_i got=%0d want=8190", bus.out_i); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL dec_max_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [2*DW-1:0] e, g;
    dec_log2 = 4'd2;
    idle(3);
    push_sample(14'h3FFF, 14'sd8191, 14'sd8191);
    push_sample(14'h3FFF, 14'sd8191, 14'sd8191);
    idle(2);
    reset_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_i !== 14'h0) begin bad++; $display("FAIL rmid_out_i got=%h want=0", bus.out_i); end
    total++; if (dac_data !== 14'h2000) begin bad++; $display("FAIL rmid_dac got=%h want=2000", dac_data); end
    model_clear();
    exp_q.delete();
    idle(2);
    reset_n = 1'b1;
    idle(2);
    push_sample(14'h2800, 14'sd3000, -14'sd1000);
    push_sample(14'h1800, -14'sd2000, 14'sd5000);
    push_sample(14'h3000, 14'sd7000, 14'sd100);
    push_sample(14'h0400, 14'sd1500, -14'sd6000);
    wait_results(1, 10, ok);
    total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL rmid_count got=%0d want=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rmid_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_gaps_enable();
    bit ok;
    logic [2*DW-1:0] e, g, last_e;
    dec_log2 = 4'd1;
    idle(3);
    push_sample(14'h3A00, 14'sd4000, 14'sd2000); idle(1);
    push_sample(14'h0F00, -14'sd3000, 14'sd6500); idle(1);
    push_sample(14'h2200, 14'sd8191, -14'sd8192); idle(1);
    push_sample(14'h1100, 14'sd250, 14'sd7777); idle(1);
    wait_results(2, 10, ok);
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL gaps_count got=%0d want=2", got_q.size()); end
    last_e = exp_q[exp_q.size() - 1];
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL gaps_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    dec_log2 = 4'd2;
    idle(3);
    push_sample(14'h3FFF, 14'sd8191, 14'sd8191);
    push_sample(14'h3FFF, 14'sd8191, 14'sd8191);
    idle(4);
    enable = 1'b0;
    model_clear();
    idle(4);
    enable = 1'b1;
    idle(4);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL en_no_result got=%0d want=0", got_q.size()); end
    total++; if ({bus.out_i, bus.out_q} !== last_e) begin bad++; $display("FAIL en_retained got=%h want=%h", {bus.out_i, bus.out_q}, last_e); end
    push_sample(14'h1234, 14'sd2222, -14'sd3333);
    push_sample(14'h2345, -14'sd4444, 14'sd5555);
    push_sample(14'h3456, 14'sd6666, 14'sd1111);
    push_sample(14'h0567, -14'sd7777, -14'sd2222);
    wait_results(1, 10, ok);
    total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL en_count got=%0d want=1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL en_sb got=%h want=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.adc_data = '0;
    bus.lo_sin = '0;
    bus.lo_cos = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturate();
    test_overrun();
    test_dec_switch();
    test_reset_mid();
    test_gaps_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
